// File: rtl/io_check_pkg.sv
// Shared definitions for the io_check I/O shell: mode encodings, FSM states,
// pattern counter width and the pattern replication helper.
package io_check_pkg;

  localparam int unsigned CNT_W     = 16;
  // Widest supported channel; the replication helper always builds this many bits.
  localparam int unsigned PAT_MAX_W = 256;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_ONES  = 2'd1;
  localparam logic [1:0] MODE_ZEROS = 2'd2;
  localparam logic [1:0] MODE_PAT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

  // Counter value tiled across the widest channel; callers keep the low bits they need.
  function automatic logic [PAT_MAX_W-1:0] pat_replicate(input logic [CNT_W-1:0] cnt);
    return {(PAT_MAX_W / CNT_W){cnt}};
  endfunction

endpackage

// File: rtl/io_check_delay.sv
// Fixed-depth {valid, data} shift register used to align launched pattern words
// with the loopback return. Synchronous active-low clear empties every stage.
module io_check_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          i_clr_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);

  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][DW-1:0] r_data;

  // Shift one stage per cycle; clear drops every in-flight word.
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_vld  <= '0;
      r_data <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_data[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/io_check_top.sv
// Chip-edge I/O shell: registers NUM_CH channels (pass / force ones / force zeros /
// counter pattern) and runs a loopback self-check of channel 0 against loop_in.
// Optional macro IO_CHECK_FIRST_ERR_EN adds first_err_idx / first_err_syn capture.
module io_check_top
  import io_check_pkg::*;
#(
  parameter int unsigned       WIDTH      = 70,
  parameter int unsigned       NUM_CH     = 3,
  parameter int unsigned       LOOP_LAT   = 2,
  parameter int unsigned       RUN_CYCLES = 32,
  parameter logic [CNT_W-1:0]  SEED       = 16'h0001
) (
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]        loop_in,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    busy,
  output logic                    passed,
  output logic                    failed,
  output logic [CNT_W-1:0]        err_count
`ifdef IO_CHECK_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0]        first_err_idx,
  output logic [WIDTH-1:0]        first_err_syn
`endif
);

  localparam logic [CNT_W:0]   RUN_LAUNCH = (CNT_W+1)'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] RUN_CMP    = CNT_W'(RUN_CYCLES);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W:0]          r_launch;
  logic [CNT_W-1:0]        r_cmp;
  logic [CNT_W-1:0]        r_err;
  logic [NUM_CH*WIDTH-1:0] r_out;
  logic [NUM_CH*WIDTH-1:0] w_out_next;
  logic                    r_lvld;
  logic [WIDTH-1:0]        r_lpat;
  logic [WIDTH-1:0]        w_pat;
  logic                    w_run_entry;
  logic                    w_launch;
  logic                    w_dly_clr_n;
  logic                    w_dly_vld;
  logic [WIDTH-1:0]        w_dly_data;
  logic                    w_mismatch;

  assign w_pat       = WIDTH'(pat_replicate(r_cnt));
  assign w_run_entry = (r_state != ST_RUN) && (w_state_next == ST_RUN);
  assign w_launch    = (r_state == ST_RUN) && (r_launch < RUN_LAUNCH);
  assign w_dly_clr_n = reset_l && !w_run_entry;
  assign w_mismatch  = w_dly_vld && (loop_in != w_dly_data);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: start is only honoured outside RUN; RUN ends once every word is compared.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (r_cmp == RUN_CMP) w_state_next = (r_err == '0) ? ST_PASS : ST_FAIL;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state; PASS/FAIL persist until the next start.
  always_comb begin
    busy   = 1'b0;
    passed = 1'b0;
    failed = 1'b0;
    unique case (r_state)
      ST_RUN:  busy   = 1'b1;
      ST_PASS: passed = 1'b1;
      ST_FAIL: failed = 1'b1;
      default: ;
    endcase
  end

  // Output data select for the next cycle.
  always_comb begin
    w_out_next = '0;
    unique case (mode)
      MODE_PASS:  w_out_next = in_data;
      MODE_ONES:  w_out_next = '1;
      MODE_ZEROS: w_out_next = '0;
      MODE_PAT:   w_out_next = {NUM_CH{w_pat}};
    endcase
  end

  // Registered pad-side data.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_out <= '0;
    end else begin
      r_out <= w_out_next;
    end
  end

  // Pattern counter, launch/compare counters and error count; all restart on RUN entry.
  // r_lvld/r_lpat mirror the timing of out_data so the delay line only spans the loopback.
  always_ff @(posedge clk) begin
    if (!reset_l || w_run_entry) begin
      r_cnt    <= SEED;
      r_launch <= '0;
      r_cmp    <= '0;
      r_err    <= '0;
      r_lvld   <= 1'b0;
      r_lpat   <= '0;
    end else begin
      if (r_state == ST_RUN) r_cnt <= r_cnt + 16'd1;
      r_lvld <= w_launch;
      r_lpat <= w_pat;
      if (w_launch) r_launch <= r_launch + 17'd1;
      if (w_dly_vld) r_cmp <= r_cmp + 16'd1;
      if (w_mismatch && (r_err != {CNT_W{1'b1}})) r_err <= r_err + 16'd1;
    end
  end

  io_check_delay #(
    .DEPTH (LOOP_LAT),
    .DW    (WIDTH)
  ) u_delay (
    .clk     (clk),
    .i_clr_n (w_dly_clr_n),
    .i_vld   (r_lvld),
    .i_data  (r_lpat),
    .o_vld   (w_dly_vld),
    .o_data  (w_dly_data)
  );

  assign out_data  = r_out;
  assign err_count = r_err;

`ifdef IO_CHECK_FIRST_ERR_EN
  logic             r_ferr_hit;
  logic [CNT_W-1:0] r_ferr_idx;
  logic [WIDTH-1:0] r_ferr_syn;

  // Capture index and syndrome of the first mismatch of a run only.
  always_ff @(posedge clk) begin
    if (!reset_l || w_run_entry) begin
      r_ferr_hit <= 1'b0;
      r_ferr_idx <= {CNT_W{1'b1}};
      r_ferr_syn <= '0;
    end else if (w_mismatch && !r_ferr_hit) begin
      r_ferr_hit <= 1'b1;
      r_ferr_idx <= r_cmp;
      r_ferr_syn <= loop_in ^ w_dly_data;
    end
  end

  assign first_err_idx = r_ferr_idx;
  assign first_err_syn = r_ferr_syn;
`endif

endmodule

// File: tb/tb_io_check_top.sv
// Scoreboard bench for io_check_top: a default instance (SEED 1, 32 compares) and a
// wrap instance (SEED FFFE, 4 compares), each with an ideal 2-cycle external loopback.
module tb_io_check_top;

  localparam int unsigned W  = 70;
  localparam int unsigned NC = 3;
  localparam int unsigned DW = W * NC;
  localparam logic [W-1:0] FLIP = 70'h20;
  localparam logic [W-1:0] REP1 = 70'h01_0001_0001_0001_0001;

  logic          clk = 1'b0;
  logic          reset_l, start, start2, flip_en;
  logic [1:0]    mode;
  logic [DW-1:0] in_data;
  logic [W-1:0]  loop_in, loop_in2;
  logic [DW-1:0] out_data, out_data2;
  logic          busy, passed, failed, busy2, passed2, failed2;
  logic [15:0]   err_count, err_count2;
`ifdef IO_CHECK_FIRST_ERR_EN
  logic [15:0]   first_err_idx, first_err_idx2;
  logic [W-1:0]  first_err_syn, first_err_syn2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  io_check_top #(
    .WIDTH(W), .NUM_CH(NC), .LOOP_LAT(2), .RUN_CYCLES(32), .SEED(16'h0001)
  ) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .mode(mode), .in_data(in_data),
    .loop_in(loop_in), .out_data(out_data), .busy(busy), .passed(passed),
    .failed(failed), .err_count(err_count)
`ifdef IO_CHECK_FIRST_ERR_EN
    , .first_err_idx(first_err_idx), .first_err_syn(first_err_syn)
`endif
  );

  io_check_top #(
    .WIDTH(W), .NUM_CH(NC), .LOOP_LAT(2), .RUN_CYCLES(4), .SEED(16'hFFFE)
  ) dut2 (
    .clk(clk), .reset_l(reset_l), .start(start2), .mode(mode), .in_data(in_data),
    .loop_in(loop_in2), .out_data(out_data2), .busy(busy2), .passed(passed2),
    .failed(failed2), .err_count(err_count2)
`ifdef IO_CHECK_FIRST_ERR_EN
    , .first_err_idx(first_err_idx2), .first_err_syn(first_err_syn2)
`endif
  );

  // External loopback: two register stages from out_data channel 0 back to loop_in.
  logic [W-1:0] lb1 = '0, lb2 = '0, lb1b = '0, lb2b = '0;
  always @(posedge clk) begin
    lb1  <= out_data[W-1:0];
    lb2  <= lb1;
    lb1b <= out_data2[W-1:0];
    lb2b <= lb1b;
  end
  // Fault injection: corrupt bit 5 of the returned word carrying pattern 0008 (compare 7).
  assign loop_in  = lb2 ^ ((flip_en && (lb2[15:0] == 16'h0008)) ? FLIP : '0);
  assign loop_in2 = lb2b;

  function automatic logic [W-1:0] rep(input logic [15:0] c);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = c[i % 16];
    return r;
  endfunction

  function automatic logic [DW-1:0] rep3(input logic [15:0] c);
    return {rep(c), rep(c), rep(c)};
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Cycle-scheduled scoreboard: entries are due on a given cycle count, in order.
  int            due_q[$];
  int            sel_q[$];
  logic [DW-1:0] exp_q[$];
  string         name_q[$];

  task automatic expect_at(input int due, input int sel, input logic [DW-1:0] v,
                           input string nm);
    due_q.push_back(due);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  function automatic logic [DW-1:0] actual(input int s);
    case (s)
      0:       return out_data;
      1:       return DW'(busy);
      2:       return DW'(passed);
      3:       return DW'(failed);
      4:       return DW'(err_count);
      5:       return DW'(out_data2[15:0]);
      6:       return DW'(busy2);
      default: return '0;
    endcase
  endfunction

  always @(negedge clk) begin : sched_mon
    int    s;
    string nm;
    logic [DW-1:0] ev;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      s  = sel_q.pop_front();
      ev = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, actual(s), ev);
    end
  end

  // Completion scoreboard: expected run results pushed at start, popped when a flag rises.
  logic          rp_q[$];
  logic [15:0]   re_q[$];
  logic [15:0]   ri_q[$];
  logic [W-1:0]  rs_q[$];
  logic          rp2_q[$];
  logic          done_p = 1'b0, done2_p = 1'b0;

  always @(negedge clk) begin : res_mon
    logic ep;
    logic [15:0] ee, ei;
    logic [W-1:0] es;
    if ((passed || failed) && !done_p) begin
      if (rp_q.size() == 0) begin
        check("unexpected completion", DW'(1), DW'(0));
      end else begin
        ep = rp_q.pop_front();
        ee = re_q.pop_front();
        ei = ri_q.pop_front();
        es = rs_q.pop_front();
        check("run passed", DW'(passed), DW'(ep));
        check("run failed", DW'(failed), DW'(!ep));
        check("run err_count", DW'(err_count), DW'(ee));
        check("run busy low", DW'(busy), DW'(0));
`ifdef IO_CHECK_FIRST_ERR_EN
        check("first_err_idx", DW'(first_err_idx), DW'(ei));
        check("first_err_syn", DW'(first_err_syn), DW'(es));
`endif
      end
    end
    if ((passed2 || failed2) && !done2_p) begin
      if (rp2_q.size() == 0) begin
        check("unexpected completion dut2", DW'(1), DW'(0));
      end else begin
        ep = rp2_q.pop_front();
        check("wrap passed", DW'(passed2), DW'(ep));
        check("wrap err_count", DW'(err_count2), DW'(0));
      end
    end
    done_p  = passed || failed;
    done2_p = passed2 || failed2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_result(input logic p, input logic [15:0] e, input logic [15:0] i,
                             input logic [W-1:0] s);
    rp_q.push_back(p);
    re_q.push_back(e);
    ri_q.push_back(i);
    rs_q.push_back(s);
  endtask

  initial begin : stim
    int n, m;
    reset_l = 1'b0; start = 1'b0; start2 = 1'b0; flip_en = 1'b0;
    mode = 2'd0; in_data = '0;
    tick(); tick();
    in_data = {70'h0, 70'h3_DEAD_BEEF_0000_1234, 70'h0};
    expect_at(cyc, 0, '0, "reset out_data");
    expect_at(cyc, 1, '0, "reset busy");
    expect_at(cyc, 2, '0, "reset passed");
    expect_at(cyc, 3, '0, "reset failed");
    expect_at(cyc, 4, '0, "reset err_count");
    expect_at(cyc, 5, '0, "reset out_data2");
    tick();
    reset_l = 1'b1;
    expect_at(cyc + 1, 0, {70'h0, 70'h3_DEAD_BEEF_0000_1234, 70'h0}, "pass-through ch1");
    tick();
    mode = 2'd1;
    expect_at(cyc + 1, 0, '1, "force ones");
    tick();
    mode = 2'd2;
    expect_at(cyc + 1, 0, '0, "force zeros");
    expect_at(cyc + 1, 1, '0, "busy idle");
    expect_at(cyc + 1, 2, '0, "passed idle");
    expect_at(cyc + 1, 3, '0, "failed idle");
    tick();
    mode = 2'd3;
    expect_at(cyc + 1, 0, {REP1, REP1, REP1}, "pattern held at seed");
    tick();

    // Clean run
    start = 1'b1;
    n = cyc;
    expect_at(n + 1, 1, DW'(1), "busy rises");
    for (int k = 0; k < 4; k++) expect_at(n + 2 + k, 0, rep3(16'(k + 1)), "pattern seq");
    push_result(1'b1, 16'd0, 16'hFFFF, '0);
    tick();
    start = 1'b0;
    repeat (45) tick();

    // Run with one corrupted return word
    flip_en = 1'b1;
    start = 1'b1;
    n = cyc;
    expect_at(n + 1, 3, '0, "failed cleared on start");
    push_result(1'b0, 16'd1, 16'd7, FLIP);
    tick();
    start = 1'b0;
    repeat (45) tick();

    // Mid-run start ignored, then reset aborts the run
    start = 1'b1;
    n = cyc;
    expect_at(n + 1, 1, DW'(1), "busy from FAIL restart");
    expect_at(n + 1, 3, '0, "failed cleared");
    tick();
    start = 1'b0;
    repeat (14) tick();
    start = 1'b1;
    m = cyc;
    expect_at(m + 1, 1, DW'(1), "busy after ignored start");
    expect_at(m + 1, 4, DW'(1), "err_count mid-run");
    expect_at(m + 1, 0, rep3(16'(m - n)), "pattern continues");
    expect_at(m + 2, 0, rep3(16'(m - n + 1)), "pattern continues 2");
    tick();
    start = 1'b0;
    tick();
    reset_l = 1'b0;
    tick();
    reset_l = 1'b1;
    expect_at(cyc, 0, '0, "abort out_data");
    expect_at(cyc, 1, '0, "abort busy");
    expect_at(cyc, 2, '0, "abort passed");
    expect_at(cyc, 3, '0, "abort failed");
    expect_at(cyc, 4, '0, "abort err_count");
    flip_en = 1'b0;
    tick();
    start = 1'b1;
    push_result(1'b1, 16'd0, 16'hFFFF, '0);
    tick();
    start = 1'b0;
    repeat (45) tick();

    // Wrap instance
    start2 = 1'b1;
    n = cyc;
    expect_at(n + 1, 6, DW'(1), "wrap busy");
    expect_at(n + 2, 5, DW'(16'hFFFE), "wrap pat FFFE");
    expect_at(n + 3, 5, DW'(16'hFFFF), "wrap pat FFFF");
    expect_at(n + 4, 5, DW'(16'h0000), "wrap pat 0000");
    expect_at(n + 5, 5, DW'(16'h0001), "wrap pat 0001");
    rp2_q.push_back(1'b1);
    tick();
    start2 = 1'b0;
    repeat (20) tick();

    check("pending run results", DW'(rp_q.size()), '0);
    check("pending wrap results", DW'(rp2_q.size()), '0);
    check("pending scheduled checks", DW'(due_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
